// File: rtl/ks_sub_pkg.sv
// ks_sub_pkg: shared constants, stage bundle type and register-placement
// helper for the pipelined Kogge-Stone subtractor.
package ks_sub_pkg;

  localparam int unsigned KS_WIDTH  = 8;
  localparam int unsigned KS_TAG_W  = 4;
  localparam int unsigned LEVELS    = $clog2(KS_WIDTH);
  // A pipeline register follows every STAGE_GAP prefix levels.
  localparam int unsigned STAGE_GAP = 2;

  // Per-stage bundle; lane -1 occupies bit 0 of p/g.
  typedef struct packed {
    logic                valid;
    logic [KS_WIDTH:0]   p;
    logic [KS_WIDTH:0]   g;
    logic                a_msb;
    logic                b_msb;
    logic [KS_TAG_W-1:0] tag;
  } ks_stage_t;

  // True when a register sits after prefix level lvl (1-based). The last
  // level is registered together with post-processing instead.
  function automatic bit reg_after_level(int unsigned lvl, int unsigned levels);
    return (lvl < levels) && ((lvl % STAGE_GAP) == 0);
  endfunction

endpackage

// File: rtl/ks_sub_pipe_level.sv
// ks_prefix_level: one Kogge-Stone prefix level (0-based LVL).
// Ports: p_in/g_in  group propagate/generate per node (node 0 = lane -1)
//        p_out/g_out combined group signals after this level
module ks_prefix_level #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LVL   = 0
) (
  input  logic [WIDTH:0] p_in,
  input  logic [WIDTH:0] g_in,
  output logic [WIDTH:0] p_out,
  output logic [WIDTH:0] g_out
);

  localparam int unsigned SPAN = 1 << LVL;

  for (genvar n = 0; n <= WIDTH; n++) begin : g_lane
    if (n < SPAN) begin : g_pass
      // Partner would lie below lane -1: nothing to combine.
      assign p_out[n] = p_in[n];
      assign g_out[n] = g_in[n];
    end else if (n < 2 * SPAN) begin : g_grey
      // Partner group already reaches lane -1 (p = 0), so only g matters.
      assign p_out[n] = 1'b0;
      assign g_out[n] = g_in[n] | (p_in[n] & g_in[n-SPAN]);
    end else begin : g_black
      assign p_out[n] = p_in[n] & p_in[n-SPAN];
      assign g_out[n] = g_in[n] | (p_in[n] & g_in[n-SPAN]);
    end
  end

endmodule

// File: rtl/ks_sub_pipe.sv
// ks_sub_pipe: pipelined Kogge-Stone subtractor, diff = a - b - bin.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/a/b/bin/in_tag on
//        the input side; out_valid/out_ready/diff/bout/ovf/zero/out_tag on
//        the output side. Global-stall flow control: in_ready = adv.
module ks_sub_pipe
  import ks_sub_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH,
  parameter int unsigned TAG_W = KS_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned N_LVL = $clog2(WIDTH);

  // Stage bundle; p0 keeps the original lane propagate for post-processing.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] p0;
    logic [WIDTH:0]   p;
    logic [WIDTH:0]   g;
    logic             a_msb;
    logic             b_msb;
    logic [TAG_W-1:0] tag;
  } node_t;

  logic             adv;
  logic [WIDTH-1:0] p_lane;
  logic [WIDTH-1:0] g_lane;
  node_t            pre;
  node_t            s0;
  node_t            node [N_LVL+1];
  node_t            fin;
  logic [WIDTH-1:0] diff_c;
  logic             cout_c;
  logic             unused_p;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Pre-processing of a + ~b + ~bin; lane -1 carries g = ~bin, p = 0.
  assign p_lane = a ^ ~b;
  assign g_lane = a & ~b;
  assign pre = '{valid: in_valid, p0: p_lane, p: {p_lane, 1'b0},
                 g: {g_lane, ~bin}, a_msb: a[WIDTH-1], b_msb: b[WIDTH-1],
                 tag: in_tag};

  // S0: register after pre-processing.
  always_ff @(posedge clk) begin
    if (rst)      s0.valid <= 1'b0;
    else if (adv) s0       <= pre;
  end
  assign node[0] = s0;

  // Prefix levels, registered after every STAGE_GAP levels.
  for (genvar k = 1; k <= N_LVL; k++) begin : g_lvl
    logic [WIDTH:0] lp;
    logic [WIDTH:0] lg;
    node_t          raw;

    ks_prefix_level #(.WIDTH(WIDTH), .LVL(k - 1)) u_level (
      .p_in  (node[k-1].p),
      .g_in  (node[k-1].g),
      .p_out (lp),
      .g_out (lg)
    );

    always_comb begin
      raw   = node[k-1];
      raw.p = lp;
      raw.g = lg;
    end

    if (reg_after_level(k, N_LVL)) begin : g_reg
      node_t r;
      always_ff @(posedge clk) begin
        if (rst)      r.valid <= 1'b0;
        else if (adv) r       <= raw;
      end
      assign node[k] = r;
    end else begin : g_wire
      assign node[k] = raw;
    end
  end

  // Post-processing. The top node spans lanes 0..WIDTH-1 only, so lane -1
  // is folded in here with one last grey cell to form the carry out.
  assign fin      = node[N_LVL];
  assign diff_c   = fin.p0 ^ fin.g[WIDTH-1:0];
  assign cout_c   = fin.g[WIDTH] | (fin.p[WIDTH] & fin.g[0]);
  assign unused_p = ^fin.p[WIDTH-1:0];

  // Final stage drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= fin.valid;
      diff      <= diff_c;
      bout      <= ~cout_c;
      ovf       <= (fin.a_msb ^ fin.b_msb) & (diff_c[WIDTH-1] ^ fin.a_msb);
      zero      <= (diff_c == '0);
      out_tag   <= fin.tag;
    end
  end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// tb_ks_sub_pipe: self-checking bench for ks_sub_pipe (WIDTH = 8, TAG_W = 4)
// using an arithmetic reference model and an in-order expectation queue.
module tb_ks_sub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;
  logic [3:0] out_tag;

  always #5 clk = ~clk;

  ks_sub_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t ref_sub(input logic [7:0] x, input logic [7:0] y,
                                   input logic c, input logic [3:0] t);
    exp_t r;
    int   u;
    int   s;
    u      = int'(x) - int'(y) - int'(c);
    s      = int'($signed(x)) - int'($signed(y)) - int'(c);
    r.diff = 8'(u);
    r.bout = (u < 0);
    r.ovf  = (s < -128) || (s > 127);
    r.zero = (r.diff == 8'h00);
    r.tag  = t;
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.diff = diff;
    o.bout = bout;
    o.ovf  = ovf;
    o.zero = zero;
    o.tag  = out_tag;
    return o;
  endfunction

  // Updates the model for the coming edge, then applies new inputs after
  // the edge and returns at the following negedge for sampling.
  task automatic drive(input logic iv, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic [3:0] t, input logic ordy,
                       input logic r);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b, bin, in_tag));
    end
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    a         = x;
    b         = y;
    bin       = c;
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h want 00", diff); end
    n_tests++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b want 0", bout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", zero); end
    n_tests++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] va[5];
    logic [7:0] vb[5];
    logic       vc[5];
    exp_t       ve[5];
    int         lat;
    va = '{8'h05, 8'h00, 8'h80, 8'h10, 8'h10};
    vb = '{8'h03, 8'h01, 8'h01, 8'h10, 8'h10};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // {diff, bout, ovf, zero, tag}
    ve = '{{8'h02, 1'b0, 1'b0, 1'b0, 4'd0},
           {8'hFF, 1'b1, 1'b0, 1'b0, 4'd1},
           {8'h7F, 1'b0, 1'b1, 1'b0, 4'd2},
           {8'hFF, 1'b1, 1'b0, 1'b0, 4'd3},
           {8'h00, 1'b0, 1'b0, 1'b1, 4'd4}};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], 4'(i), 1'b1, 1'b0);
      lat = 0;
      for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
        if (out_valid === 1'b1) lat = cyc;
      end
      n_tests++;
      if (lat != 3) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, lat); end
      n_tests++;
      if (observed() !== ve[i]) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got %h want %h", i, observed(), ve[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0] sa[8];
    logic [7:0] sb[8];
    logic       sc[8];
    exp_t       want;
    exp_t       saved;
    logic       saved_valid;
    logic       prev_stall;
    int         idx;
    int         retired;
    for (int i = 0; i < 8; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      sc[i] = 1'($urandom);
    end
    idx = 0; retired = 0; prev_stall = 1'b0;
    saved = '0; saved_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && retired < 8; cyc++) begin
      if (idx < 8) drive(1'b1, sa[idx], sb[idx], sc[idx], 4'(idx), 1'((cyc % 2) == 0), 1'b0);
      else         drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'((cyc % 2) == 0), 1'b0);
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL stream_in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (prev_stall) begin
        n_tests++;
        if (observed() !== saved || out_valid !== saved_valid) begin
          n_fail++;
          $display("FAIL stream_stall_hold: got %h/%b want %h/%b", observed(), out_valid, saved, saved_valid);
        end
      end
      if (out_valid === 1'b1) begin
        want = ref_sub(sa[retired], sb[retired], sc[retired], 4'(retired));
        n_tests++;
        if (observed() !== want) begin
          n_fail++;
          $display("FAIL stream_result[%0d]: got %h want %h", retired, observed(), want);
        end
        if (out_ready) retired++;
      end
      prev_stall  = out_valid && !out_ready;
      saved       = observed();
      saved_valid = out_valid;
      if (in_valid && in_ready) idx++;
    end
    n_tests++;
    if (retired != 8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", retired); end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 4'(8 + i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_full: got %b want 1", out_valid); end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || observed() !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL flush_cleared: got %b/%h want 0/0", out_valid, observed());
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < N && cyc < 60000) begin
      drive(1'(sent < N && $urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
      cyc++;
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL rand_in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: got result %h want none", observed());
        end else if (observed() !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_result[%0d]: got %h want %h", got, observed(), exp_q[0]);
        end
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
    end
    n_tests++;
    if (got != N) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got, N); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bin       = 1'b0;
    in_tag    = 4'h0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_stream();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
